hsv_core_issue_scoreboard: RTL
==============================

Name: hsv_core_issue_scoreboard

Overview:
Issue-stage control block sitting between decode and execution dispatch, directly in front of hsv_core_issue_regfile.
- Holds one decoded instruction and tracks pending destination registers in a per-register busy bitmap.
- Stalls on RAW/WAW hazards and drives the regfile read addresses.
- Forwards same-cycle writeback data, and passes the writeback stream through to the regfile write port.
- Emits operand-complete instructions through a registered valid/ready output.

Parameters:
- PAYLOAD_W, 64: width of the opaque micro-op payload carried alongside the operands.
- BYPASS_EN, 1: 1 lets a writeback in the current cycle resolve a hazard on the same register and forward its data; 0 requires the busy bit to clear first.

Ports:
- clk_core in 1: core clock, all state on rising edge.
- rst_n in 1: asynchronous active-low reset.
- flush in 1: squash held and output instructions, clear scoreboard.
- in_valid in 1: decode offers an instruction.
- in_ready out 1: the block accepts the instruction this cycle.
- in_rs1_addr, in_rs2_addr in reg_addr: source register numbers.
- in_uses_rs1, in_uses_rs2 in 1: source is actually read.
- in_rd_addr in reg_addr: destination register.
- in_rd_write in 1: instruction writes rd.
- in_payload in PAYLOAD_W: opaque micro-op bits.
- rs1_addr, rs2_addr out reg_addr: regfile read addresses.
- rs1_data, rs2_data in word: regfile read data, combinational from rs*_addr.
- wb_valid in 1: an execution unit retires a result.
- wb_addr in reg_addr: writeback destination.
- wb_data in word: writeback value.
- wr_en out 1: regfile write enable.
- wr_addr out reg_addr: regfile write address.
- wr_data out word: regfile write data.
- out_valid out 1: an issued instruction is available.
- out_ready in 1: execution accepts it.
- out_rs1_data, out_rs2_data out word: resolved operands.
- out_rd_addr out reg_addr: destination register.
- out_rd_write out 1: instruction writes rd.
- out_payload out PAYLOAD_W: micro-op bits.

Behaviour:
- Reset:
  - busy[31:0] = 0, hold_valid = 0, out_valid = 0, all out_* data = 0.
  - in_ready is 1 in the first cycle after reset release.
- Hold register:
  - in_ready = !flush && (!hold_valid || fire).
  - An accept (in_valid && in_ready) loads the hold register at the edge.
- Regfile read addresses:
  - rs1_addr = hold.uses_rs1 ? hold.rs1 : 0. rs2_addr is formed the same way.
  - Register x0 reads as 0 from the regfile and is never busy.
- Writeback pass-through:
  - wr_en = wb_valid && wb_addr != 0.
  - wr_addr and wr_data are wb_addr and wb_data, combinational.
  - The regfile does not forward write data to a same-cycle read; this block does.
- Hazards (each requires hold_valid):
  - wbhit(r) = BYPASS_EN && wb_valid && wb_addr == r.
  - RAW on rs1 = uses_rs1 && rs1 != 0 && busy[rs1] && !wbhit(rs1). RAW on rs2 is formed the same way.
  - WAW = rd_write && rd != 0 && busy[rd] && !(wb_valid && wb_addr == rd).
- Issue:
  - fire = hold_valid && !hazard && (!out_valid || out_ready) && !flush.
  - On fire, the output register loads the hold contents.
  - Operand data = wbhit(rs) ? wb_data : rs_data, and 0 when the source is unused.
- Scoreboard update at each edge:
  - Clear busy[wb_addr] when wb_valid.
  - Set busy[rd] when fire && rd_write && rd != 0.
  - Set and clear of the same register in the same cycle: set wins.
  - A writeback to a non-busy register still writes the regfile and leaves busy unchanged; a simulation assertion flags it.
- Output:
  - out_valid clears when out_ready && !fire, and sets on fire.
  - Output data is held stable while out_valid && !out_ready.
- Latency and throughput:
  - Accept at edge k leads to out_valid high after edge k+1 at the earliest.
  - Sustained throughput is 1 instruction per cycle with no hazards.
- Flush:
  - At the next edge, hold_valid = 0, out_valid = 0 and busy = 0.
  - Same-cycle fire and accept are suppressed.
  - A same-cycle wb_valid still writes the regfile.
- Reset asserted mid-operation: all state clears asynchronously, and pending writebacks are lost.

Decomposition:
- Add to hsv_core_pkg:
  - issue_req_t struct: rs1, rs2, rd, uses_rs1, uses_rs2, rd_write, payload.
  - issue_out_t struct: rs1_data, rs2_data, rd, rd_write, payload.
  - Reuse the existing reg_addr and word types.
- One sub-module, hsv_core_issue_busy_table:
  - 32-bit busy bitmap with set and clear ports and set-wins priority; x0 is hardwired to 0.
  - Two combinational lookup ports plus one for rd.

Test Plan:
- Reset, then a single instruction with rs1=3, rs2=15, rd=5, regfile holding 0xdeadbeef and 0xcafebabe -> out_valid two cycles after accept, operands 0xdeadbeef / 0xcafebabe, busy[5]=1.
- Instruction A writes x5; instruction B reads x5; no writeback arrives -> B stalls in hold and in_ready=0. Then wb x5=0x12345678 arrives -> B fires in that cycle with rs1 operand 0x12345678 (BYPASS_EN=1) and busy[5] clears.
- Same B stall with BYPASS_EN=0 -> B issues one cycle after the writeback and reads 0x12345678 from the regfile.
- A instruction with rd=0 and sources x0 -> never busy, operands 0, no stall.
- Back-to-back independent instructions with out_ready toggling 1,0,1 -> no loss or duplication, outputs held while stalled, 1 instr/cycle when ready.
- With busy[7]=1 and a held instruction, assert flush together with wb x7=0xa5a5a5a5 -> regfile x7 = 0xa5a5a5a5, busy all 0, hold_valid and out_valid 0 next cycle. A new instruction reading x7 then issues without stall.

Source files
------------

// File: rtl/hsv_core_pkg.sv
// Shared core types: register/word types and the issue-stage request and
// result records passed between decode, the scoreboard and dispatch.
package hsv_core_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned NUM_REGS        = 32;
  // Widest micro-op payload an issue slot can carry; narrower payloads are
  // zero-extended into it.
  localparam int unsigned ISSUE_PAYLOAD_W = 64;

  typedef logic [4:0]      reg_addr;
  typedef logic [XLEN-1:0] word;

  // Decoded instruction waiting for its operands.
  typedef struct packed {
    reg_addr                    rs1;
    reg_addr                    rs2;
    reg_addr                    rd;
    logic                       uses_rs1;
    logic                       uses_rs2;
    logic                       rd_write;
    logic [ISSUE_PAYLOAD_W-1:0] payload;
  } issue_req_t;

  // Operand-complete instruction handed to execution.
  typedef struct packed {
    word                        rs1_data;
    word                        rs2_data;
    reg_addr                    rd;
    logic                       rd_write;
    logic [ISSUE_PAYLOAD_W-1:0] payload;
  } issue_out_t;

endpackage

// File: rtl/hsv_core_issue_busy_table.sv
// Per-register pending-write bitmap. Set (issue of a writer) beats clear
// (writeback) on the same register; x0 can never be busy.
module hsv_core_issue_busy_table
  import hsv_core_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_all_i,
  input  logic                set_en_i,
  input  reg_addr             set_addr_i,
  input  logic                clr_en_i,
  input  reg_addr             clr_addr_i,
  input  reg_addr             rs1_addr_i,
  input  reg_addr             rs2_addr_i,
  input  reg_addr             rd_addr_i,
  output logic                rs1_busy_o,
  output logic                rs2_busy_o,
  output logic                rd_busy_o,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Next bitmap: clear, then set so that set wins, then flush and x0 override.
  // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
    if (clear_all_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // Bitmap register.
  // NOTE: the bitmap is 32 flops, not a RAM, so it is safe and cheap to reset as a whole.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign rs1_busy_o = busy_q[rs1_addr_i];
  assign rs2_busy_o = busy_q[rs2_addr_i];
  assign rd_busy_o  = busy_q[rd_addr_i];
  assign busy_o     = busy_q;

endmodule

// File: rtl/hsv_core_issue_scoreboard.sv
// Issue stage: holds one decoded instruction, stalls it on RAW/WAW hazards
// against the busy bitmap, reads operands from the regfile (forwarding a
// same-cycle writeback) and hands it to execution through a registered
// valid/ready slot. The writeback stream passes straight to the regfile.
module hsv_core_issue_scoreboard
  import hsv_core_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 64,   // must not exceed ISSUE_PAYLOAD_W
  parameter bit          BYPASS_EN = 1'b1
) (
  input  logic                 clk_core,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  reg_addr              in_rs1_addr,
  input  reg_addr              in_rs2_addr,
  input  logic                 in_uses_rs1,
  input  logic                 in_uses_rs2,
  input  reg_addr              in_rd_addr,
  input  logic                 in_rd_write,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output reg_addr              rs1_addr,
  output reg_addr              rs2_addr,
  input  word                  rs1_data,
  input  word                  rs2_data,
  input  logic                 wb_valid,
  input  reg_addr              wb_addr,
  input  word                  wb_data,
  output logic                 wr_en,
  output reg_addr              wr_addr,
  output word                  wr_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output word                  out_rs1_data,
  output word                  out_rs2_data,
  output reg_addr              out_rd_addr,
  output logic                 out_rd_write,
  output logic [PAYLOAD_W-1:0] out_payload
);

  issue_req_t          hold_q, hold_d;
  logic                hold_valid_q;
  issue_out_t          out_q, out_d;
  logic                out_valid_q;
  logic                rs1_busy, rs2_busy, rd_busy;
  logic [NUM_REGS-1:0] busy_vec;
  logic                rs1_wbhit, rs2_wbhit;
  logic                raw_rs1, raw_rs2, waw, hazard, fire, accept;

  assign hold_d = '{rs1:      in_rs1_addr,
                    rs2:      in_rs2_addr,
                    rd:       in_rd_addr,
                    uses_rs1: in_uses_rs1,
                    uses_rs2: in_uses_rs2,
                    rd_write: in_rd_write,
                    payload:  ISSUE_PAYLOAD_W'(in_payload)};

  // Writeback pass-through; x0 is never written.
  assign wr_en   = wb_valid && (wb_addr != '0);
  assign wr_addr = wb_addr;
  assign wr_data = wb_data;

  // Unused sources read x0 so the regfile returns zero.
  assign rs1_addr = hold_q.uses_rs1 ? hold_q.rs1 : '0;
  assign rs2_addr = hold_q.uses_rs2 ? hold_q.rs2 : '0;

  // A same-cycle writeback resolves a source hazard when bypass is on. The
  // x0 guard keeps a stray writeback to x0 from leaking into an operand.
  assign rs1_wbhit = BYPASS_EN && wb_valid && (wb_addr == hold_q.rs1) && (hold_q.rs1 != '0);
  assign rs2_wbhit = BYPASS_EN && wb_valid && (wb_addr == hold_q.rs2) && (hold_q.rs2 != '0);

  assign raw_rs1 = hold_q.uses_rs1 && (hold_q.rs1 != '0) && rs1_busy && !rs1_wbhit;
  assign raw_rs2 = hold_q.uses_rs2 && (hold_q.rs2 != '0) && rs2_busy && !rs2_wbhit;
  // The new writer re-sets busy[rd] over the retiring one, so WAW clears
  // on a matching writeback regardless of bypass.
  assign waw     = hold_q.rd_write && (hold_q.rd != '0) && rd_busy &&
                   !(wb_valid && (wb_addr == hold_q.rd));
  assign hazard  = hold_valid_q && (raw_rs1 || raw_rs2 || waw);

  assign fire     = hold_valid_q && !hazard && (!out_valid_q || out_ready) && !flush;
  assign in_ready = !flush && (!hold_valid_q || fire);
  assign accept   = in_valid && in_ready;

  // Operand selection for the instruction leaving the hold register.
  always_comb begin
    out_d          = '0;
    out_d.rd       = hold_q.rd;
    out_d.rd_write = hold_q.rd_write;
    out_d.payload  = hold_q.payload;
    if (hold_q.uses_rs1) out_d.rs1_data = rs1_wbhit ? wb_data : rs1_data;
    if (hold_q.uses_rs2) out_d.rs2_data = rs2_wbhit ? wb_data : rs2_data;
  end

  // Hold register: loads on accept, empties on fire or flush.
  // NOTE: state is updated with <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      if (flush)       hold_valid_q <= 1'b0;
      else if (accept) hold_valid_q <= 1'b1;
      else if (fire)   hold_valid_q <= 1'b0;
      if (accept) hold_q <= hold_d;
    end
  end

  // Output slot: loads on fire, drains on out_ready, data frozen while stalled.
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      if (flush)          out_valid_q <= 1'b0;
      else if (fire)      out_valid_q <= 1'b1;
      else if (out_ready) out_valid_q <= 1'b0;
      if (fire) out_q <= out_d;
    end
  end

  hsv_core_issue_busy_table u_busy (
    .clk         (clk_core),
    .rst_n       (rst_n),
    .clear_all_i (flush),
    .set_en_i    (fire && hold_q.rd_write && (hold_q.rd != '0)),
    .set_addr_i  (hold_q.rd),
    .clr_en_i    (wb_valid),
    .clr_addr_i  (wb_addr),
    .rs1_addr_i  (hold_q.rs1),
    .rs2_addr_i  (hold_q.rs2),
    .rd_addr_i   (hold_q.rd),
    .rs1_busy_o  (rs1_busy),
    .rs2_busy_o  (rs2_busy),
    .rd_busy_o   (rd_busy),
    .busy_o      (busy_vec)
  );

  // A writeback should only ever retire a register that was marked pending.
  assert property (@(posedge clk_core) disable iff (!rst_n)
                   (wb_valid && (wb_addr != '0)) |-> busy_vec[wb_addr]);

  assign out_valid    = out_valid_q;
  assign out_rs1_data = out_q.rs1_data;
  assign out_rs2_data = out_q.rs2_data;
  assign out_rd_addr  = out_q.rd;
  assign out_rd_write = out_q.rd_write;
  assign out_payload  = out_q.payload[PAYLOAD_W-1:0];

endmodule
